branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Dynamic branch predictor in the fetch/decode path. It produces the `prediction` bit that the control unit uses to decide whether a jump or branch needs an ID/EX flush.
- It holds a direct-mapped table of 2-bit saturating counters, indexed by PC bits.
- Counters are updated when the EX stage resolves a conditional branch.
- It also flags mispredictions and keeps saturating statistics counters for performance analysis.

Parameters:
- PC_W, 64, width of program counter inputs
- INDEX_BITS, 4, log2 of table entries (default 16 entries)
- CNT_W, 32, width of statistics counters

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- lookup_valid  input  1  fetch-side lookup request (a conditional branch is in ID)
- lookup_pc  input  PC_W  PC of the instruction being looked up
- prediction  output  1  1 = predict taken; combinational from table and lookup inputs
- update_valid  input  1  EX-side resolution of one conditional branch this cycle
- update_pc  input  PC_W  PC of the resolved branch
- update_taken  input  1  actual outcome (branchtaken from the EX comparator)
- update_pred  input  1  prediction originally issued for this branch (carried down the pipeline)
- mispredict  output  1  combinational: resolved outcome differs from issued prediction
- branch_count  output  CNT_W  number of resolved branches since reset
- mispredict_count  output  CNT_W  number of mispredictions since reset

Behaviour:
- Clock and reset are fixed: one clock; reset is synchronous and active-high (ports clk, rst).
- Index: idx = pc[INDEX_BITS+1:2], since instructions are word aligned. All other PC bits are ignored; there are no tags, so aliasing is accepted.
- Counter states:
  - 00 STRONG_NT
  - 01 WEAK_NT
  - 10 WEAK_T
  - 11 STRONG_T
- prediction = lookup_valid & table[idx(lookup_pc)][1]. Zero latency, no register. prediction = 0 whenever lookup_valid = 0.
- Update, on the clock edge when update_valid = 1 and rst = 0:
  - update_taken = 1: the counter increments, saturating at 11.
  - update_taken = 0: the counter decrements, saturating at 00.
  - Exactly one entry changes per cycle.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update value (no bypass). The new value is visible from the next cycle.
- mispredict = update_valid & (update_pred != update_taken). Purely combinational; it must not depend on the current table contents.
- Statistics counters:
  - branch_count increments by 1 on every cycle with update_valid = 1.
  - mispredict_count increments by 1 when mispredict = 1.
  - Both saturate at all-ones and never wrap.
  - Both are registered outputs: the value is visible the cycle after the event.
- Reset values:
  - All table entries 01 (WEAK_NT).
  - branch_count = 0, mispredict_count = 0.
  - prediction and mispredict follow their combinational definitions from reset state, so prediction = 0 immediately after reset.
- Reset mid-operation: rst has priority. An update presented in the same cycle as rst = 1 is discarded, and statistics are cleared, not incremented.
- X-safety: update_pc and update_taken are don't-care when update_valid = 0, and must not affect state.

Decomposition:
- Shared package holds:
  - the 2-bit counter state constants (STRONG_NT, WEAK_NT, WEAK_T, STRONG_T);
  - the reset value WEAK_NT;
  - the index-extraction function or constant offset (2).
- The existing RISC-V opcode and ALUOp constants move into the same package so the control unit and predictor share one definition.
- One natural sub-module: sat_counter2. It is a combinational next-state function (state, taken) -> next state, instantiated per update path.
- The statistics counters stay inline.

Test Plan:
- Reset default: assert rst for 2 cycles, then lookup_valid = 1 with any PC -> prediction = 0, branch_count = 0, mispredict_count = 0.
- Training: 2 updates to PC 0x40 with taken = 1 (update_pred = 0 both times):
  - after the 1st update, lookup of 0x40 -> prediction = 1 (state 10);
  - after the 2nd, state 11;
  - mispredict_count = 2, branch_count = 2.
- Saturation and hysteresis:
  - from STRONG_T at 0x40, one update taken = 0 -> prediction still 1;
  - a 2nd update taken = 0 -> prediction = 0;
  - 3 further not-taken updates -> state 00, no underflow;
  - then one taken update -> prediction still 0.
- Same-cycle lookup and update on PC 0x80 (state 01, update taken = 1): in the update cycle prediction = 0; in the next cycle prediction = 1.
- Aliasing: train PC 0x40 to STRONG_T, then look up PC 0x80 (same idx with INDEX_BITS = 4) -> prediction = 1; look up PC 0x44 -> prediction = 0.
- Reset priority: update_valid = 1, update_taken = 1, update_pred = 0 in the same cycle as rst = 1:
  - mispredict = 1 combinationally;
  - the next cycle shows branch_count = 0, mispredict_count = 0 and the entry still 01.
- Statistics saturation, with CNT_W overridden to 4: 20 mispredicting updates -> both counters hold 15.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch/decode control path.
//
// Holds the 2-bit saturating counter encodings used by the branch predictor,
// the position of the table index inside a PC, and the RISC-V opcode and ALUOp
// encodings. The control unit and the predictor both use these definitions.
package branch_predictor_pkg;

  // Predictor counter states. The MSB is the taken/not-taken prediction.
  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  // Value loaded into every table entry at reset.
  localparam logic [1:0] CTR_RESET = WEAK_NT;

  // Instructions are word aligned, so the table index starts at PC bit 2.
  localparam int IDX_LSB = 2;

  // RISC-V base opcodes (inst[6:0]).
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // ALUOp from the main decoder to the ALU decoder.
  localparam logic [1:0] ALUOP_ADD    = 2'b00;  // loads, stores, address calc
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;  // compare for branches
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;  // decode funct3/funct7
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;  // decode funct3 with immediate

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: next-state function of a 2-bit saturating counter.
//
// Ports:
//   state      in   current counter value
//   taken      in   resolved branch outcome (1 = count up, 0 = count down)
//   next_state out  counter value after the update, saturating at 00 and 11
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next_state
);

  always_comb begin
    // NOTE: default assignment first so every path drives next_state and no latch is inferred.
    next_state = state;
    if (taken) begin
      if (state != STRONG_T) next_state = state + 2'd1;
    end else begin
      if (state != STRONG_NT) next_state = state - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped table of 2-bit saturating counters.
//
// The table is indexed by pc[INDEX_BITS+1:2] with no tags, so branches that
// share those bits alias onto one entry. Lookups read the table directly;
// an update in the same cycle is written at the clock edge and is visible
// to lookups from the next cycle onward.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   lookup_valid      a conditional branch is being looked up this cycle
//   lookup_pc         PC of that branch
//   prediction        1 = predict taken (combinational, 0 when no lookup)
//   update_valid      a conditional branch resolved in EX this cycle
//   update_pc         PC of the resolved branch
//   update_taken      actual outcome of the resolved branch
//   update_pred       prediction issued for that branch at fetch time
//   mispredict        combinational: outcome differs from issued prediction
//   branch_count      saturating count of resolved branches since reset
//   mispredict_count  saturating count of mispredictions since reset
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int PC_W       = 64,
  parameter int INDEX_BITS = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lookup_valid,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             prediction,
  input  logic             update_valid,
  input  logic [PC_W-1:0]  update_pc,
  input  logic             update_taken,
  input  logic             update_pred,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int IDX_HI  = IDX_LSB + INDEX_BITS - 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]            table_q [ENTRIES];
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;
  logic [1:0]            update_state;
  logic [1:0]            update_next;

  assign lookup_idx = lookup_pc[IDX_HI:IDX_LSB];
  assign update_idx = update_pc[IDX_HI:IDX_LSB];

  // PC bits outside the index field carry no information for this table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[PC_W-1:IDX_HI+1], lookup_pc[IDX_LSB-1:0],
                            update_pc[PC_W-1:IDX_HI+1], update_pc[IDX_LSB-1:0]};

  // Reads the stored table, never the value being written this cycle.
  assign prediction = lookup_valid & table_q[lookup_idx][1];

  // Depends only on the resolution inputs, not on the table.
  assign mispredict = update_valid & (update_pred ^ update_taken);

  assign update_state = table_q[update_idx];

  sat_counter2 u_sat_counter2 (
    .state      (update_state),
    .taken      (update_taken),
    .next_state (update_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is reset entry by entry because every counter must start at WEAK_NT.
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_RESET;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (update_valid) begin
      table_q[update_idx] <= update_next;
      if (branch_count != CNT_MAX)
        branch_count <= branch_count + CNT_W'(1);
      if (mispredict && (mispredict_count != CNT_MAX))
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [63:0] lookup_pc;
  logic        update_valid;
  logic [63:0] update_pc;
  logic        update_taken;
  logic        update_pred;

  logic        prediction, mispredict;
  logic [31:0] branch_count, mispredict_count;

  // Second instance with narrow statistics counters for the saturation check.
  logic        prediction_n, mispredict_n;
  logic [3:0]  branch_count_n, mispredict_count_n;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .prediction       (prediction),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_pred      (update_pred),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  branch_predictor #(.CNT_W(4)) dut_narrow (
    .clk              (clk),
    .rst              (rst),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .prediction       (prediction_n),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_pred      (update_pred),
    .mispredict       (mispredict_n),
    .branch_count     (branch_count_n),
    .mispredict_count (mispredict_count_n)
  );

  typedef struct {
    logic        rst;
    logic        lv;
    logic [63:0] lpc;
    logic        uv;
    logic [63:0] upc;
    logic        ut;
    logic        up;
    logic        exp_pred;
    logic        exp_misp;
    int          exp_bc;
    int          exp_mc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic r, logic lv, logic [63:0] lpc, logic uv,
                             logic [63:0] upc, logic ut, logic up,
                             logic ep, logic em, int bc, int mc);
    vec_t x;
    x.rst = r; x.lv = lv; x.lpc = lpc; x.uv = uv; x.upc = upc; x.ut = ut;
    x.up = up; x.exp_pred = ep; x.exp_misp = em; x.exp_bc = bc; x.exp_mc = mc;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; lookup_valid = 1'b0; lookup_pc = '0; update_valid = 1'b0;
    update_pc = '0; update_taken = 1'b0; update_pred = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Inputs are applied for one cycle; combinational outputs and the
    // counters (reflecting all earlier cycles) are checked at the negedge.
    //              rst lv lpc    uv upc    ut up  pred misp bc  mc
    vecs.push_back(v(0, 1, 64'h40,  0, 64'h0,  0, 0,  0, 0,  0, 0)); // reset default
    vecs.push_back(v(0, 1, 64'h123, 0, 64'h0,  0, 0,  0, 0,  0, 0));
    vecs.push_back(v(0, 0, 64'h40,  1, 64'h40, 1, 0,  0, 1,  0, 0)); // train 01->10
    vecs.push_back(v(0, 1, 64'h40,  1, 64'h40, 1, 0,  1, 1,  1, 1)); // 10->11
    vecs.push_back(v(0, 1, 64'h40,  0, 64'h0,  0, 0,  1, 0,  2, 2));
    vecs.push_back(v(0, 1, 64'h40,  1, 64'h40, 0, 1,  1, 1,  2, 2)); // 11->10
    vecs.push_back(v(0, 1, 64'h40,  0, 64'h0,  0, 0,  1, 0,  3, 3)); // hysteresis
    vecs.push_back(v(0, 0, 64'h40,  1, 64'h40, 0, 1,  0, 1,  3, 3)); // 10->01
    vecs.push_back(v(0, 1, 64'h40,  0, 64'h0,  0, 0,  0, 0,  4, 4));
    vecs.push_back(v(0, 1, 64'h40,  1, 64'h40, 0, 0,  0, 0,  4, 4)); // 01->00
    vecs.push_back(v(0, 1, 64'h40,  1, 64'h40, 0, 0,  0, 0,  5, 4)); // stays 00
    vecs.push_back(v(0, 1, 64'h40,  1, 64'h40, 0, 0,  0, 0,  6, 4)); // stays 00
    vecs.push_back(v(0, 1, 64'h40,  1, 64'h40, 1, 0,  0, 1,  7, 4)); // 00->01
    vecs.push_back(v(0, 1, 64'h40,  0, 64'h0,  0, 0,  0, 0,  8, 5)); // still NT
    vecs.push_back(v(0, 1, 64'h80,  1, 64'h80, 1, 0,  0, 1,  8, 5)); // same-cycle, no bypass
    vecs.push_back(v(0, 1, 64'h80,  0, 64'h0,  0, 0,  1, 0,  9, 6)); // visible next cycle
    vecs.push_back(v(0, 0, 64'h40,  1, 64'h40, 1, 1,  0, 0,  9, 6)); // 10->11
    vecs.push_back(v(0, 1, 64'h80,  0, 64'h0,  0, 0,  1, 0, 10, 6)); // alias of 0x40
    vecs.push_back(v(0, 1, 64'h44,  0, 64'h0,  0, 0,  0, 0, 10, 6)); // other entry
    vecs.push_back(v(0, 1, 64'h44,  0, 64'h44, 1, 0,  0, 0, 10, 6)); // no valid: ignored
    vecs.push_back(v(0, 1, 64'h44,  0, 64'h0,  0, 0,  0, 0, 10, 6));
    vecs.push_back(v(0, 1, 64'h40,  1, 64'h44, 1, 0,  1, 1, 10, 6)); // idx1 01->10
    vecs.push_back(v(0, 1, 64'h44,  0, 64'h0,  0, 0,  1, 0, 11, 7));
    vecs.push_back(v(0, 1, 64'h40,  0, 64'h0,  0, 0,  1, 0, 11, 7)); // idx0 untouched
    vecs.push_back(v(1, 1, 64'h48,  1, 64'h48, 1, 0,  0, 1, 11, 7)); // reset wins
    vecs.push_back(v(0, 1, 64'h48,  0, 64'h0,  0, 0,  0, 0,  0, 0));
    vecs.push_back(v(0, 1, 64'h40,  0, 64'h0,  0, 0,  0, 0,  0, 0)); // table cleared
    vecs.push_back(v(0, 1, 64'h48,  1, 64'h48, 1, 0,  0, 1,  0, 0)); // 01->10
    vecs.push_back(v(0, 1, 64'h48,  0, 64'h0,  0, 0,  1, 0,  1, 1));

    foreach (vecs[i]) begin
      rst          = vecs[i].rst;
      lookup_valid = vecs[i].lv;
      lookup_pc    = vecs[i].lpc;
      update_valid = vecs[i].uv;
      update_pc    = vecs[i].upc;
      update_taken = vecs[i].ut;
      update_pred  = vecs[i].up;
      @(negedge clk);
      check($sformatf("v%0d prediction", i), 64'(prediction), 64'(vecs[i].exp_pred));
      check($sformatf("v%0d mispredict", i), 64'(mispredict), 64'(vecs[i].exp_misp));
      check($sformatf("v%0d branch_count", i), 64'(branch_count), 64'(vecs[i].exp_bc));
      check($sformatf("v%0d mispredict_count", i), 64'(mispredict_count), 64'(vecs[i].exp_mc));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    // Statistics saturation: the narrow counters already hold 1 each.
    lookup_valid = 1'b0;
    update_valid = 1'b1; update_pc = 64'h40; update_taken = 1'b1; update_pred = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 13) begin
        check("narrow branch_count at 15", 64'(branch_count_n), 64'd15);
        check("narrow mispredict_count at 15", 64'(mispredict_count_n), 64'd15);
      end
    end
    update_valid = 1'b0;
    @(negedge clk);
    check("narrow branch_count saturated", 64'(branch_count_n), 64'd15);
    check("narrow mispredict_count saturated", 64'(mispredict_count_n), 64'd15);
    check("wide branch_count", 64'(branch_count), 64'd21);
    check("wide mispredict_count", 64'(mispredict_count), 64'd21);
    check("narrow mispredict idle", 64'(mispredict_n), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
